unrot_pipe: RTL

Pipelined inverse of the combinational barrel rotator: rotates an N-bit word LEFT by k, undoing a right rotation by the same k. There is one register stage per shift stage, so the rotation network meets timing at large N (256+). The block takes words on a valid/ready input, carries k alongside the data through the pipeline, and delivers results on a valid/ready output with full backpressure. It is intended as the receive-side de-rotation partner of the rotator; rot followed by unrot_pipe with the same k is the identity.

---
 rtl/unrot_pipe.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/unrot_pipe.sv
// -----------------------------------------------------------------------------
// unrot_pipe
//
// Purpose:
//   Pipelined left barrel rotator. It undoes a right rotation by the same
//   amount, so rot followed by unrot_pipe with equal k is the identity.
//   out_bits[i] = in_bits[(i + k) mod N].
//
//   There is one register stage per shift stage, which keeps the rotation
//   network fast at large N. Stage j rotates left by N >> (j+1) when k[j] is
//   set. The still-unused k bits travel with the data. The pipeline has full
//   valid/ready backpressure, and bubbles collapse.
//
// Ports:
//   clk        single clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset; empties the pipeline
//   in_valid   input word and k are valid
//   in_ready   block accepts the input this cycle
//   in_bits    word to de-rotate; index 0 is the leftmost bit
//   in_k       rotate amount; k[0] weighs N/2, k[log2_N-1] weighs 1
//   out_valid  out_bits holds a result
//   out_ready  downstream accepts the result
//   out_bits   left-rotated word (last stage data register)
//   occupancy  number of words currently in flight (0..log2_N)
// -----------------------------------------------------------------------------
module unrot_pipe #(
   parameter int N      = 256,
   parameter int log2_N = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [0:N-1]      in_bits,
   input  logic [0:log2_N-1] in_k,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [0:N-1]      out_bits,
   output logic [log2_N:0]   occupancy
);

   localparam int L  = log2_N;
   // Stage j (j < L-1) keeps only the k bits that later stages still need:
   // in_k[j+1 .. L-1], which is L-1-j bits. These slices are packed
   // back to back, and the total is L*(L-1)/2 bits.
   localparam int KT = (L * (L - 1)) / 2;
   localparam logic [L:0] OCC_ONE = (L + 1)'(1);

   logic [0:L-1][0:N-1] data_reg;
   logic [0:L-1][0:N-1] data_next;
   logic [0:L-1][0:N-1] src_data;
   logic [0:L-1][0:N-1] rot_data;
   logic [0:L-1]        v_reg;
   logic [0:L-1]        v_next;
   logic [0:L-1]        src_v;
   logic [0:L-1]        src_kbit;
   logic [0:L-1]        adv;
   logic [0:L-1]        ld;
   logic [0:KT-1]       k_reg;
   logic [0:KT-1]       k_next;
   logic [L:0]          occ_reg;
   logic [L:0]          occ_next;
   logic                in_fire;
   logic                out_fire;

   genvar gi, bi;
   generate
      for (gi = 0; gi < L; gi++) begin : g_stage
         localparam int SHIFT = N >> (gi + 1);
         // OFF is the start of this stage's k slice. POFF is the start of the
         // previous stage's slice.
         localparam int OFF   = gi * (L - 1) - (gi * (gi - 1)) / 2;
         localparam int POFF  = (gi - 1) * (L - 1) - ((gi - 1) * (gi - 2)) / 2;

         if (gi == 0) begin : g_src
            assign src_data[gi] = in_bits;
            assign src_v[gi]    = in_valid;
            assign src_kbit[gi] = in_k[0];
         end else begin : g_src
            assign src_data[gi] = data_reg[gi-1];
            assign src_v[gi]    = v_reg[gi-1];
            // The first bit of the previous slice belongs to this stage.
            assign src_kbit[gi] = k_reg[POFF];
         end

         // Fixed left rotation by SHIFT: d[i] = src[(i + SHIFT) mod N].
         for (bi = 0; bi < N; bi++) begin : g_bit
            localparam int SRC_IDX = (bi + SHIFT) % N;
            assign rot_data[gi][bi] = src_data[gi][SRC_IDX];
         end

         // A stage can advance when it or any later stage has a bubble, or
         // when the output is being drained. This is the closed form of
         // adv[j] = !v[j] || adv[j+1]. It avoids a chained
         // self-referencing vector.
         assign adv[gi] = out_ready || !(&v_reg[gi:L-1]);
         assign ld[gi]  = adv[gi] && src_v[gi];

         assign v_next[gi]    = adv[gi] ? src_v[gi] : v_reg[gi];
         assign data_next[gi] = !ld[gi]      ? data_reg[gi] :
                                src_kbit[gi] ? rot_data[gi] : src_data[gi];

         // The last stage consumes its own k bit and stores none.
         if (gi < L - 1) begin : g_k
            localparam int W = L - 1 - gi;
            logic [0:W-1] k_rem;
            if (gi == 0) begin : g_rem
               assign k_rem = in_k[1:L-1];
            end else begin : g_rem
               assign k_rem = k_reg[POFF+1 +: W];
            end
            assign k_next[OFF +: W] = ld[gi] ? k_rem : k_reg[OFF +: W];
         end
      end
   endgenerate

   assign in_ready  = adv[0];
   assign out_valid = v_reg[L-1];
   assign out_bits  = data_reg[L-1];
   assign occupancy = occ_reg;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   always_comb begin
      occ_next = occ_reg;
      if (in_fire && !out_fire) begin
         occ_next = occ_reg + OCC_ONE;
      end else if (!in_fire && out_fire) begin
         occ_next = occ_reg - OCC_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_reg <= '0;
         v_reg    <= '0;
         k_reg    <= '0;
         occ_reg  <= '0;
      end else begin
         data_reg <= data_next;
         v_reg    <= v_next;
         k_reg    <= k_next;
         occ_reg  <= occ_next;
      end
   end

endmodule
